// File: rtl/spi_master.sv
// SPI mode-0 master: byte-stream handshake in, MOSI/SCLK/CS out, received bytes on rx_*.
// A frame stays open across bytes until one is flagged last; the next byte may be queued late in the current one.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_data_i,
    input  logic       byte_last_i,
    output logic       byte_rdy_o,
    output logic       rx_vld_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    input  logic       spi_miso_i
);

    typedef enum logic [1:0] {IDLE, XFER, WAIT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] divCnt_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shift_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       csN_q;
    logic       rdy_q;
    logic       rxVld_q;
    logic [7:0] rxData_q;
    logic       rxPend_q;
    logic       last_q;
    logic [7:0] nxtData_q;
    logic       nxtLast_q;
    logic       nxtVld_q;
    logic       guard_q;

    logic       tick;
    logic       accept;
    logic       rise;
    logic       fall;
    logic [7:0] divCnt_d;
    logic [2:0] bitCnt_d;

    assign tick     = (divCnt_q == DIV_LAST);
    assign divCnt_d = tick ? 8'd0 : divCnt_q + 8'd1;
    assign bitCnt_d = bitCnt_q + 3'd1;
    assign accept   = byte_vld_i && rdy_q;
    assign rise     = (state_q == XFER) && tick && !sclk_q;
    assign fall     = (state_q == XFER) && tick && sclk_q;

    // The shift register doubles as TX source and RX sink: MISO enters at bit 0 on each
    // rising edge while the outgoing bit is copied to MOSI on the following falling edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            divCnt_q  <= 8'd0;
            bitCnt_q  <= 3'd0;
            shift_q   <= 8'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            csN_q     <= 1'b1;
            rdy_q     <= 1'b0;
            rxVld_q   <= 1'b0;
            rxData_q  <= 8'd0;
            rxPend_q  <= 1'b0;
            last_q    <= 1'b0;
            nxtData_q <= 8'd0;
            nxtLast_q <= 1'b0;
            nxtVld_q  <= 1'b0;
            guard_q   <= 1'b0;
        end else begin
            rxVld_q  <= 1'b0;
            rxPend_q <= 1'b0;
            if (rxPend_q) begin
                rxVld_q  <= 1'b1;
                rxData_q <= shift_q;
            end

            case (state_q)
                IDLE: begin
                    if (guard_q) begin
                        divCnt_q <= divCnt_d;
                        if (tick) begin
                            guard_q <= 1'b0;
                            rdy_q   <= 1'b1;
                        end
                    end else if (accept) begin
                        state_q  <= XFER;
                        csN_q    <= 1'b0;
                        divCnt_q <= 8'd0;
                        bitCnt_q <= 3'd0;
                        rdy_q    <= 1'b0;
                        shift_q  <= byte_data_i;
                        mosi_q   <= byte_data_i[7];
                        last_q   <= byte_last_i;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                XFER: begin
                    divCnt_q <= divCnt_d;
                    if (accept) begin
                        nxtData_q <= byte_data_i;
                        nxtLast_q <= byte_last_i;
                        nxtVld_q  <= 1'b1;
                        rdy_q     <= 1'b0;
                    end else if (rxPend_q && !last_q && !nxtVld_q) begin
                        rdy_q <= 1'b1;
                    end

                    if (rise) begin
                        sclk_q   <= 1'b1;
                        shift_q  <= {shift_q[6:0], spi_miso_i};
                        bitCnt_q <= bitCnt_d;
                        rxPend_q <= (bitCnt_q == 3'd7);
                    end

                    // bitCnt has wrapped to 0 only on the 8th falling edge of a byte
                    if (fall) begin
                        sclk_q <= 1'b0;
                        if (bitCnt_q != 3'd0) begin
                            mosi_q <= shift_q[7];
                        end else begin
                            nxtVld_q <= 1'b0;
                            rdy_q    <= 1'b0;
                            if (accept) begin
                                shift_q <= byte_data_i;
                                mosi_q  <= byte_data_i[7];
                                last_q  <= byte_last_i;
                            end else if (nxtVld_q) begin
                                shift_q <= nxtData_q;
                                mosi_q  <= nxtData_q[7];
                                last_q  <= nxtLast_q;
                            end else if (last_q) begin
                                state_q <= HOLD;
                                mosi_q  <= 1'b0;
                            end else begin
                                state_q <= WAIT;
                                rdy_q   <= 1'b1;
                            end
                        end
                    end
                end

                WAIT: begin
                    if (accept) begin
                        state_q  <= XFER;
                        divCnt_q <= 8'd0;
                        rdy_q    <= 1'b0;
                        shift_q  <= byte_data_i;
                        mosi_q   <= byte_data_i[7];
                        last_q   <= byte_last_i;
                    end
                end

                HOLD: begin
                    divCnt_q <= divCnt_d;
                    if (tick) begin
                        state_q <= IDLE;
                        csN_q   <= 1'b1;
                        guard_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_rdy_o = rdy_q;
    assign rx_vld_o   = rxVld_q;
    assign rx_data_o  = rxData_q;
    assign busy_o     = (state_q != IDLE);
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = csN_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=4 instance for frame timing, CLK_DIV=1 instance for the fastest divider.
// Cycle 0 of each window is the sample where byte_vld_i && byte_rdy_o are seen; outputs are sampled on negedges.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rstN;
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       loopback;
    logic       sel;

    logic       rdy4, rxVld4, busy4, sclk4, mosi4, csN4, miso4;
    logic [7:0] rxData4;
    logic       rdy1, rxVld1, busy1, sclk1, mosi1, csN1, miso1;
    logic [7:0] rxData1;

    logic       rdyM, rxVldM, busyM, sclkM, mosiM, csM;
    logic [7:0] rxDataM;

    always #5 clk = ~clk;

    assign miso4 = loopback ? mosi4 : 1'b0;
    assign miso1 = 1'b0;

    assign rdyM    = sel ? rdy1    : rdy4;
    assign rxVldM  = sel ? rxVld1  : rxVld4;
    assign busyM   = sel ? busy1   : busy4;
    assign sclkM   = sel ? sclk1   : sclk4;
    assign mosiM   = sel ? mosi1   : mosi4;
    assign csM     = sel ? csN1    : csN4;
    assign rxDataM = sel ? rxData1 : rxData4;

    spi_master #(.CLK_DIV(4)) dut4 (
        .clk_i(clk), .rst_n_i(rstN),
        .byte_vld_i(vld), .byte_data_i(data), .byte_last_i(last),
        .byte_rdy_o(rdy4), .rx_vld_o(rxVld4), .rx_data_o(rxData4), .busy_o(busy4),
        .spi_sclk_o(sclk4), .spi_mosi_o(mosi4), .spi_cs_n_o(csN4), .spi_miso_i(miso4)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_n_i(rstN),
        .byte_vld_i(vld), .byte_data_i(data), .byte_last_i(last),
        .byte_rdy_o(rdy1), .rx_vld_o(rxVld1), .rx_data_o(rxData1), .busy_o(busy1),
        .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_n_o(csN1), .spi_miso_i(miso1)
    );

    int passCnt = 0;
    int checkCnt = 0;

    int         riseCyc[$];
    logic       mosiRise[$];
    int         fallCyc[$];
    int         rxCyc[$];
    logic [7:0] rxByte[$];
    int         hsCyc[$];
    int         csFallCyc[$];
    int         csRiseCyc[$];
    logic       sclkLog[256];
    logic       csLog[256];
    logic       rdyLog[256];
    logic       mosiLog[256];
    logic       busyLog[256];

    int         offerAt, offerEnd, resetAt;
    logic [7:0] offerData;
    logic       offerLast;
    logic       dropPending;
    logic       prevSclk, prevCs;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Offers a byte and returns on the sample where the handshake is seen (cycle 0).
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int waited;
        @(negedge clk);
        vld = 1'b1; data = d; last = l;
        waited = 0;
        while (!rdyM && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", {31'd0, rdyM}, 32'd1);
        dropPending = 1'b1;
        prevSclk = sclkM;
        prevCs = csM;
        riseCyc.delete(); mosiRise.delete(); fallCyc.delete(); rxCyc.delete();
        rxByte.delete(); hsCyc.delete(); csFallCyc.delete(); csRiseCyc.delete();
        for (int i = 0; i < 256; i++) begin
            sclkLog[i] = 1'b0; csLog[i] = 1'b0; rdyLog[i] = 1'b0; mosiLog[i] = 1'b0; busyLog[i] = 1'b0;
        end
        offerAt = 0; offerEnd = 0; resetAt = 0;
    endtask

    task automatic runWindow(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (dropPending) begin vld = 1'b0; dropPending = 1'b0; end
            if (offerAt != 0 && c == offerAt) begin vld = 1'b1; data = offerData; last = offerLast; end
            if (offerEnd != 0 && c == offerEnd) vld = 1'b0;
            if (resetAt != 0 && c == resetAt) rstN = 1'b0;
            if (resetAt != 0 && c == resetAt + 1) rstN = 1'b1;
            sclkLog[c] = sclkM; csLog[c] = csM; rdyLog[c] = rdyM; mosiLog[c] = mosiM; busyLog[c] = busyM;
            if (sclkM && !prevSclk) begin riseCyc.push_back(c); mosiRise.push_back(mosiM); end
            if (!sclkM && prevSclk) fallCyc.push_back(c);
            if (csM && !prevCs) csRiseCyc.push_back(c);
            if (!csM && prevCs) csFallCyc.push_back(c);
            if (rxVldM) begin rxCyc.push_back(c); rxByte.push_back(rxDataM); end
            if (vld && rdyM && rstN) begin hsCyc.push_back(c); dropPending = 1'b1; end
            prevSclk = sclkM;
            prevCs = csM;
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        logic [7:0]  exp8;
        logic [15:0] exp16;
        logic        flag;

        rstN = 1'b0; vld = 1'b0; data = 8'd0; last = 1'b0; loopback = 1'b1; sel = 1'b0;
        dropPending = 1'b0; offerAt = 0; offerEnd = 0; resetAt = 0; offerData = 8'd0; offerLast = 1'b0;
        prevSclk = 1'b0; prevCs = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", {31'd0, csM}, 32'd1);
        checkOutput("rst_sclk", {31'd0, sclkM}, 32'd0);
        checkOutput("rst_mosi", {31'd0, mosiM}, 32'd0);
        checkOutput("rst_rdy", {31'd0, rdyM}, 32'd0);
        checkOutput("rst_rx_vld", {31'd0, rxVldM}, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rxDataM}, 32'h00);
        checkOutput("rst_busy", {31'd0, busyM}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rdy_after_reset", {31'd0, rdyM}, 32'd1);

        $display("[TB] single byte 0x2A last, loopback, 0x55 pulsed during hold/guard");
        applyStimulus(8'h2A, 1'b1);
        offerAt = 66; offerEnd = 72; offerData = 8'h55; offerLast = 1'b0;
        runWindow(80);
        checkOutput("t1_cs_fall", qAt(csFallCyc, 0), 1);
        checkOutput("t1_rise_count", riseCyc.size(), 8);
        exp8 = 8'h2A;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t1_rise%0d_cyc", k + 1), qAt(riseCyc, k), 1 + (2 * k + 1) * 4);
            checkOutput($sformatf("t1_rise%0d_mosi", k + 1),
                        (mosiRise.size() > k) ? {31'd0, mosiRise[k]} : 32'hFFFF, {31'd0, exp8[7 - k]});
        end
        checkOutput("t1_fall8_cyc", qAt(fallCyc, 7), 65);
        checkOutput("t1_rx_count", rxCyc.size(), 1);
        checkOutput("t1_rx_cyc", qAt(rxCyc, 0), 62);
        checkOutput("t1_rx_data", (rxByte.size() > 0) ? {24'd0, rxByte[0]} : 32'hFFFF, 32'h2A);
        checkOutput("t1_mosi_hold", {31'd0, mosiLog[66]}, 32'd0);
        checkOutput("t1_cs_rise", qAt(csRiseCyc, 0), 69);
        checkOutput("t1_busy_hold", {31'd0, busyLog[68]}, 32'd1);
        checkOutput("t1_busy_idle", {31'd0, busyLog[69]}, 32'd0);
        checkOutput("t1_guard_rdy_low", {31'd0, rdyLog[72]}, 32'd0);
        checkOutput("t1_guard_rdy_high", {31'd0, rdyLog[73]}, 32'd1);
        flag = 1'b1;
        for (int c = 69; c <= 80; c++) if (!csLog[c]) flag = 1'b0;
        checkOutput("t1_no_cs_after_ignored", {31'd0, flag}, 32'd1);
        checkOutput("t1_no_handshake_55", hsCyc.size(), 0);

        $display("[TB] back-to-back 0x2A then 0x2B");
        applyStimulus(8'h2A, 1'b0);
        offerAt = 1; offerData = 8'h2B; offerLast = 1'b1;
        runWindow(150);
        checkOutput("t2_rise_count", riseCyc.size(), 16);
        flag = (riseCyc.size() == 16) && (fallCyc.size() == 16);
        for (int k = 1; k < 16 && flag; k++)
            if (riseCyc[k] - riseCyc[k - 1] != 8 || fallCyc[k] - fallCyc[k - 1] != 8) flag = 1'b0;
        checkOutput("t2_sclk_gapless", {31'd0, flag}, 32'd1);
        checkOutput("t2_rise16_cyc", qAt(riseCyc, 15), 125);
        exp16 = 16'h2A2B;
        flag = (mosiRise.size() == 16);
        for (int k = 0; k < 16 && flag; k++) if (mosiRise[k] !== exp16[15 - k]) flag = 1'b0;
        checkOutput("t2_mosi_bits", {31'd0, flag}, 32'd1);
        checkOutput("t2_hs_cyc", qAt(hsCyc, 0), 62);
        checkOutput("t2_rdy_drop", {31'd0, rdyLog[63]}, 32'd0);
        checkOutput("t2_cs_fall_count", csFallCyc.size(), 1);
        checkOutput("t2_cs_rise", qAt(csRiseCyc, 0), 133);
        checkOutput("t2_rx_count", rxCyc.size(), 2);
        checkOutput("t2_rx0", (rxByte.size() > 0) ? {24'd0, rxByte[0]} : 32'hFFFF, 32'h2A);
        checkOutput("t2_rx1", (rxByte.size() > 1) ? {24'd0, rxByte[1]} : 32'hFFFF, 32'h2B);
        checkOutput("t2_rx_spacing", qAt(rxCyc, 1) - qAt(rxCyc, 0), 64);

        $display("[TB] 0x2B then second byte withheld 20 cycles");
        applyStimulus(8'h2B, 1'b0);
        offerAt = 85; offerData = 8'h3C; offerLast = 1'b1;
        runWindow(170);
        checkOutput("t3_wait_sclk", {31'd0, sclkLog[75]}, 32'd0);
        checkOutput("t3_wait_cs", {31'd0, csLog[75]}, 32'd0);
        checkOutput("t3_wait_rdy", {31'd0, rdyLog[75]}, 32'd1);
        checkOutput("t3_wait_busy", {31'd0, busyLog[75]}, 32'd1);
        checkOutput("t3_wait_mosi", {31'd0, mosiLog[75]}, 32'd1);
        flag = 1'b1;
        for (int c = 65; c <= 85; c++) if (sclkLog[c] || csLog[c]) flag = 1'b0;
        checkOutput("t3_wait_bus_quiet", {31'd0, flag}, 32'd1);
        checkOutput("t3_hs_cyc", qAt(hsCyc, 0), 85);
        checkOutput("t3_bit7_mosi", {31'd0, mosiLog[86]}, 32'd0);
        checkOutput("t3_first_rise_after", qAt(riseCyc, 8) - qAt(hsCyc, 0), 5);
        checkOutput("t3_cs_fall_count", csFallCyc.size(), 1);
        checkOutput("t3_rx1", (rxByte.size() > 1) ? {24'd0, rxByte[1]} : 32'hFFFF, 32'h3C);

        $display("[TB] reset mid-transfer of 0x7E");
        applyStimulus(8'h7E, 1'b1);
        resetAt = 30;
        runWindow(40);
        checkOutput("t4_cs_before", {31'd0, csLog[30]}, 32'd0);
        checkOutput("t4_sclk_before", {31'd0, sclkLog[30]}, 32'd1);
        checkOutput("t4_cs_after", {31'd0, csLog[31]}, 32'd1);
        checkOutput("t4_sclk_after", {31'd0, sclkLog[31]}, 32'd0);
        checkOutput("t4_busy_after", {31'd0, busyLog[31]}, 32'd0);
        checkOutput("t4_rdy_in_reset", {31'd0, rdyLog[31]}, 32'd0);
        checkOutput("t4_rdy_release", {31'd0, rdyLog[32]}, 32'd1);
        checkOutput("t4_no_rx", rxCyc.size(), 0);

        $display("[TB] CLK_DIV=1, 0xFF with MISO=0");
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        applyStimulus(8'hFF, 1'b1);
        runWindow(30);
        flag = !sclkLog[1];
        for (int c = 2; c <= 17; c++) if (sclkLog[c] === sclkLog[c - 1]) flag = 1'b0;
        checkOutput("t5_sclk_every_cycle", {31'd0, flag}, 32'd1);
        checkOutput("t5_rise_count", riseCyc.size(), 8);
        checkOutput("t5_rise8_cyc", qAt(riseCyc, 7), 16);
        checkOutput("t5_fall8_cyc", qAt(fallCyc, 7), 17);
        flag = (mosiRise.size() == 8);
        foreach (mosiRise[k]) if (mosiRise[k] !== 1'b1) flag = 1'b0;
        checkOutput("t5_mosi_ones", {31'd0, flag}, 32'd1);
        checkOutput("t5_rx_cyc", qAt(rxCyc, 0), 17);
        checkOutput("t5_rx_data", (rxByte.size() > 0) ? {24'd0, rxByte[0]} : 32'hFFFF, 32'h00);
        checkOutput("t5_cs_rise", qAt(csRiseCyc, 0), 18);
        checkOutput("t5_guard_low", {31'd0, rdyLog[18]}, 32'd0);
        checkOutput("t5_guard_end", {31'd0, rdyLog[19]}, 32'd1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk_i cycles; the legal range is 1..255.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port byte_vld_i, input, 1 bit: a TX byte is offered.
REQ-005 SHALL have port byte_data_i, input, 8 bits: the TX byte, sent MSB first.
REQ-006 SHALL have port byte_last_i, input, 1 bit: the offered byte ends the frame (CS released after it).
REQ-007 SHALL have port byte_rdy_o, output, 1 bit: the master accepts the byte; transfer occurs when byte_vld_i && byte_rdy_o at a clk_i edge.
REQ-008 SHALL have port rx_vld_o, output, 1 bit: a one-cycle pulse marking that a received byte is available.
REQ-009 SHALL have port rx_data_o, output, 8 bits: the byte sampled from MISO.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have ports spi_sclk_o (1 bit), spi_mosi_o (1 bit) and spi_cs_n_o (1 bit), all outputs: SPI mode 0 bus.
REQ-012 SHALL have port spi_miso_i, input, 1 bit: the slave data input.

Function
REQ-013 SHALL use only one clock (clk_i), with reset synchronous and active-low on rst_n_i.
REQ-014 SHALL implement SPI mode 0:
- SCLK idles low.
- MOSI changes only on SCLK falling edges, or when CS asserts.
- MISO is sampled on SCLK rising edges.
- MSB first.
REQ-015 SHALL implement the states IDLE, XFER, WAIT and HOLD, with these transitions:
- IDLE -> XFER on handshake.
- XFER -> XFER on a mid-frame handshake.
- XFER -> WAIT when a non-last byte completes with no next byte accepted.
- XFER -> HOLD when the last byte completes.
- WAIT -> XFER on handshake.
- HOLD -> IDLE.
REQ-016 SHALL drive byte_rdy_o high in IDLE once the CS-high guard (REQ-022) has elapsed.
REQ-017 SHALL drive byte_rdy_o high in WAIT.
REQ-018 SHALL drive byte_rdy_o high in XFER from the clk_i cycle after the 8th rising edge up to and including the 8th falling edge, but only when the current byte is not last; it SHALL be low otherwise.
REQ-019 SHALL time an accept from IDLE at cycle 0 as follows, with N = CLK_DIV:
- Cycle 1: spi_cs_n_o=0 and spi_mosi_o=bit7.
- SCLK rising edge k (k=1..8) at cycle 1+(2k-1)N.
- SCLK falling edge k at cycle 1+2kN.
REQ-020 SHALL continue a frame after a mid-frame handshake as follows:
- The new bit7 appears on MOSI at the 8th falling edge of the previous byte.
- SCLK continues with no gap.
- CS stays low.
REQ-021 SHALL behave in WAIT as follows:
- SCLK is held low and CS is held low.
- MOSI is held at the last bit.
- An accept at WAIT cycle t drives bit7 at t+1, and the first rising edge follows N cycles later.
REQ-022 SHALL behave in HOLD as follows:
- HOLD lasts N cycles after the last falling edge, then spi_cs_n_o=1.
- spi_mosi_o=0.
- byte_rdy_o stays low for N further cycles (CS-high guard).
REQ-023 SHALL update rx_data_o and pulse rx_vld_o for exactly one cycle in the clk_i cycle after each 8th rising edge; rx_data_o SHALL hold its value until the next pulse.
REQ-024 SHALL ignore byte_vld_i while byte_rdy_o=0; byte_data_i and byte_last_i SHALL be captured only on handshake.
REQ-025 SHALL use a half-period counter of 8 bits, wrapping at N-1, and a 3-bit bit counter; with CLK_DIV=1, SCLK toggles every cycle.

Reset
REQ-026 SHALL, while rst_n_i=0 at a clk_i edge, set the following:
- state = IDLE.
- spi_cs_n_o = 1, spi_sclk_o = 0, spi_mosi_o = 0.
- byte_rdy_o = 0, rx_vld_o = 0, rx_data_o = 0x00, busy_o = 0.
- counters = 0.
REQ-027 SHALL assert byte_rdy_o in the first clk_i cycle after rst_n_i returns to 1 (no guard after reset).
REQ-028 SHALL, on reset mid-transfer, abort on the same edge: CS high, SCLK low, no rx_vld_o pulse for the partial byte.

Verification
REQ-029 SHALL be verified with CLK_DIV=4, sending byte 0x2A with last=1 and MISO=MOSI looped back:
- MOSI 0,0,1,0,1,0,1,0 across 8 rising edges at cycles 5,13,...,61.
- rx_vld_o at cycle 62 with rx_data_o=0x2A.
- spi_cs_n_o=1 at cycle 69.
REQ-030 SHALL be verified with bytes 0x2A (last=0) then 0x2B (last=1) offered back-to-back:
- 16 continuous SCLK periods with CS low throughout.
- rx_data_o 0x2A then 0x2B, pulses 64 cycles apart.
REQ-031 SHALL be verified by withholding the second byte for 20 cycles after the 1st byte: the bench SHALL check WAIT, SCLK low, CS low, byte_rdy_o=1, and that after the accept the next rising edge comes N+1 cycles later.
REQ-032 SHALL be verified by dropping rst_n_i at cycle 30 of a 0x7E transfer: the next edge SHALL give CS=1 and SCLK=0, with no rx_vld_o, and byte_rdy_o=1 one cycle after release.
REQ-033 SHALL be verified with CLK_DIV=1 and byte 0xFF with MISO=0: SCLK SHALL toggle every cycle, rx_data_o SHALL be 0x00, and byte_rdy_o SHALL be low for exactly 1 cycle after CS rises.
REQ-034 SHALL be verified by pulsing byte_vld_i with 0x55 during the HOLD/guard window: the byte SHALL be ignored, with no CS assertion until byte_rdy_o=1.
